// File: rtl/viterbi_pkg.sv
// Shared definitions for the K=3 convolutional encoder and its Viterbi decoder.
package viterbi_pkg;

   localparam int unsigned K      = 3;
   localparam int unsigned BYTE_W = 8;

   localparam logic [K-1:0] G0_DEF = 3'b111;
   localparam logic [K-1:0] G1_DEF = 3'b101;

   // Trellis state {s1,s0}; encoding shared with the decoder's path selector.
   typedef enum logic [K-2:0] {
      ST_00 = 2'b00,
      ST_01 = 2'b01,
      ST_10 = 2'b10,
      ST_11 = 2'b11
   } trellis_state_e;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      TAIL
   } fsm_state_e;

   typedef struct packed {
      logic [BYTE_W-1:0] data;
      logic              last;
   } byte_beat_t;

endpackage

// File: rtl/conv_encoder_tx_if.sv
// Byte-in / symbol-out stream bundle of the convolutional encoder.
interface conv_encoder_tx_if;
   import viterbi_pkg::*;

   logic [BYTE_W-1:0] in_data;
   logic              in_valid;
   logic              in_last;
   logic              in_ready;
   logic [1:0]        sym_out;
   logic              sym_valid;
   logic              sym_ready;
   logic              sym_last;
   logic              busy;

   modport slave (
      input  in_data, in_valid, in_last, sym_ready,
      output in_ready, sym_out, sym_valid, sym_last, busy
   );

   modport master (
      output in_data, in_valid, in_last, sym_ready,
      input  in_ready, sym_out, sym_valid, sym_last, busy
   );

endinterface

// File: rtl/conv_enc_sym.sv
// Combinational code-symbol generator: {b,s1,s0} -> {c_G0, c_G1}.
module conv_enc_sym
   import viterbi_pkg::*;
#(
   parameter logic [K-1:0] G0 = G0_DEF,
   parameter logic [K-1:0] G1 = G1_DEF
) (
   input  logic       b,
   input  logic       s1,
   input  logic       s0,
   output logic [1:0] sym
);

   logic [K-1:0] window;

   assign window = {b, s1, s0};
   assign sym    = {^(G0 & window), ^(G1 & window)};

endmodule

// File: rtl/conv_encoder_tx.sv
// Rate-1/2 K=3 convolutional encoder: serialises bytes MSB first and
// terminates each frame with two zero tail bits so the trellis ends in 00.
module conv_encoder_tx
   import viterbi_pkg::*;
#(
   parameter logic [K-1:0] G0 = G0_DEF,
   parameter logic [K-1:0] G1 = G1_DEF
) (
   input  logic              clk,
   input  logic              rst,
   conv_encoder_tx_if.slave  bus
);

   localparam int unsigned       BIT_W    = 3;
   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(7);

   fsm_state_e       state, state_d;
   byte_beat_t       beat_q, beat_d;
   logic [BIT_W-1:0] bit_cnt, bit_cnt_d;
   logic             tail_cnt, tail_cnt_d;
   trellis_state_e   mem, mem_d;
   logic [1:0]       mem_v;
   logic             cur_bit;
   logic [1:0]       sym;

   assign mem_v   = mem;
   // ~bit_cnt selects bit (7 - bit_cnt), i.e. MSB first
   assign cur_bit = (state == SHIFT) ? beat_q.data[~bit_cnt] : 1'b0;

   conv_enc_sym #(.G0(G0), .G1(G1)) u_sym (
      .b   (cur_bit),
      .s1  (mem_v[1]),
      .s0  (mem_v[0]),
      .sym (sym)
   );

   // Symbol side decodes registered state only.
   assign bus.sym_valid = (state != IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.sym_last  = (state == TAIL) && tail_cnt;
   assign bus.sym_out   = (state != IDLE) ? sym : 2'b00;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         beat_q   <= '0;
         bit_cnt  <= '0;
         tail_cnt <= 1'b0;
         mem      <= ST_00;
      end else begin
         state    <= state_d;
         beat_q   <= beat_d;
         bit_cnt  <= bit_cnt_d;
         tail_cnt <= tail_cnt_d;
         mem      <= mem_d;
      end
   end

   // Next-state, byte loading and in_ready (combinational on sym_ready for back-to-back).
   always_comb begin
      state_d      = state;
      beat_d       = beat_q;
      bit_cnt_d    = bit_cnt;
      tail_cnt_d   = tail_cnt;
      mem_d        = mem;
      bus.in_ready = 1'b0;
      unique case (state)
         IDLE: begin
            bus.in_ready = !rst;
            if (bus.in_valid) begin
               beat_d    = '{data: bus.in_data, last: bus.in_last};
               bit_cnt_d = '0;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            bus.in_ready = (bit_cnt == LAST_BIT) && bus.sym_ready && !beat_q.last;
            if (bus.sym_ready) begin
               mem_d     = trellis_state_e'({cur_bit, mem_v[1]});
               bit_cnt_d = BIT_W'(bit_cnt + 1'b1);
               if (bit_cnt == LAST_BIT) begin
                  if (beat_q.last) begin
                     state_d    = TAIL;
                     tail_cnt_d = 1'b0;
                  end else if (bus.in_valid) begin
                     beat_d    = '{data: bus.in_data, last: bus.in_last};
                     bit_cnt_d = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         TAIL: begin
            if (bus.sym_ready) begin
               mem_d      = trellis_state_e'({1'b0, mem_v[1]});
               tail_cnt_d = ~tail_cnt;
               if (tail_cnt) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Self-checking bench for conv_encoder_tx against a bit-sequence reference model.
module tb_conv_encoder_tx;
   import viterbi_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_err = 0;
   int   n_chk = 0;

   logic [7:0] q[$];
   logic [1:0] none[$];
   logic [1:0] t_80[$];
   logic [1:0] t_01[$];
   logic [1:0] t_b2b[$];

   always #5 clk = ~clk;

   conv_encoder_tx_if bus ();

   conv_encoder_tx dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Message bits framed by two zero history bits and two zero tail bits;
   // symbol i is the parity of the taps over the 3-bit window ending at bit i.
   function automatic void model(input logic [7:0] bytes[$], output logic [1:0] syms[$]);
      int m[$];
      m.push_back(0);
      m.push_back(0);
      foreach (bytes[i])
         for (int j = 7; j >= 0; j--) m.push_back(int'(bytes[i][j]));
      m.push_back(0);
      m.push_back(0);
      syms = {};
      for (int i = 2; i < m.size(); i++)
         syms.push_back({1'((m[i] + m[i-1] + m[i-2]) % 2), 1'((m[i] + m[i-2]) % 2)});
   endfunction

   task automatic run_frame(input string tag, input logic [7:0] bytes[$],
                            input logic [1:0] ref_syms[$], input int stall_pct,
                            input int abort_after);
      logic [1:0] exp[$];
      logic [1:0] got[$];
      int bi = 0, cyc = 0, n_last = 0, last_at = -1, first_acc = -1, first_val = -1;
      int bubbles = 0, unstable = 0, rdy_late = 0, b2b_bad = 0;
      bit done = 1'b0, stalled = 1'b0, aborted = 1'b0;
      logic [1:0] held_sym = 2'b00;
      logic held_last = 1'b0;
      if (ref_syms.size() != 0) exp = ref_syms;
      else model(bytes, exp);
      while (!done && cyc < 4000) begin
         @(negedge clk);
         cyc++;
         if (abort_after > 0 && got.size() == abort_after) begin
            rst = 1'b1;
            #1;
            check($sformatf("%s/abort sym_valid", tag), int'(bus.sym_valid), 0);
            check($sformatf("%s/abort sym_out", tag), int'(bus.sym_out), 0);
            check($sformatf("%s/abort sym_last", tag), int'(bus.sym_last), 0);
            check($sformatf("%s/abort busy", tag), int'(bus.busy), 0);
            check($sformatf("%s/abort in_ready", tag), int'(bus.in_ready), 0);
            aborted = 1'b1;
            done    = 1'b1;
         end else begin
            if (stalled && (!bus.sym_valid || bus.sym_out !== held_sym ||
                            bus.sym_last !== held_last)) unstable++;
            if (first_val >= 0 && !bus.sym_valid) bubbles++;
            if (first_val < 0 && bus.sym_valid) first_val = cyc;
            bus.sym_ready = ($urandom_range(99) >= stall_pct);
            bus.in_valid  = (bi < bytes.size());
            bus.in_data   = (bi < bytes.size()) ? bytes[bi] : 8'h00;
            bus.in_last   = (bi == bytes.size() - 1);
            #1;
            if (bi >= bytes.size() && bus.in_ready) rdy_late++;
            if (bus.in_valid && bus.in_ready) begin
               if (first_acc < 0) first_acc = cyc;
               if (bi > 0 && got.size() + 1 != 8 * bi) b2b_bad++;
               bi++;
            end
            stalled   = bus.sym_valid && !bus.sym_ready;
            held_sym  = bus.sym_out;
            held_last = bus.sym_last;
            if (bus.sym_valid && bus.sym_ready) begin
               got.push_back(bus.sym_out);
               if (bus.sym_last) begin
                  n_last++;
                  last_at = got.size();
                  done    = 1'b1;
               end
            end
         end
      end
      check($sformatf("%s/completed", tag), int'(done), 1);
      if (aborted) return;
      check($sformatf("%s/latency", tag), first_val - first_acc, 1);
      check($sformatf("%s/count", tag), got.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got.size(); i++)
         check($sformatf("%s/sym%0d", tag, i), int'(got[i]), int'(exp[i]));
      check($sformatf("%s/last count", tag), n_last, 1);
      check($sformatf("%s/last position", tag), last_at, exp.size());
      check($sformatf("%s/bubbles", tag), bubbles, 0);
      check($sformatf("%s/stall stability", tag), unstable, 0);
      check($sformatf("%s/in_ready in frame", tag), rdy_late, 0);
      check($sformatf("%s/back-to-back accept", tag), b2b_bad, 0);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("%s/idle busy", tag), int'(bus.busy), 0);
      check($sformatf("%s/idle sym_valid", tag), int'(bus.sym_valid), 0);
      check($sformatf("%s/idle in_ready", tag), int'(bus.in_ready), 1);
      check($sformatf("%s/idle state", tag), int'(dut.mem), 0);
   endtask

   initial begin
      t_80  = {2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
      t_01  = {2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b10, 2'b11};
      t_b2b = {2'b11, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
               2'b01, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00,
               2'b00, 2'b00};
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.in_last   = 1'b0;
      bus.sym_ready = 1'b0;
      rst           = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("reset in_ready", int'(bus.in_ready), 0);
      check("reset sym_valid", int'(bus.sym_valid), 0);
      check("reset sym_out", int'(bus.sym_out), 0);
      check("reset sym_last", int'(bus.sym_last), 0);
      check("reset busy", int'(bus.busy), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("release in_ready", int'(bus.in_ready), 1);

      q = {8'h80};        run_frame("f80", q, t_80, 0, 0);
      q = {8'h01};        run_frame("f01", q, t_01, 0, 0);
      q = {8'hFF, 8'h00}; run_frame("b2b", q, t_b2b, 0, 0);
      q = {8'hA5};        run_frame("a5_stall", q, none, 40, 0);

      q = {8'h80};        run_frame("abort", q, t_80, 0, 3);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post-abort in_ready", int'(bus.in_ready), 1);
      q = {8'h80};        run_frame("f80_after_abort", q, t_80, 0, 0);

      q = {8'h01};        run_frame("two_a", q, t_01, 0, 0);
      q = {8'h80};        run_frame("two_b", q, t_80, 0, 0);

      for (int r = 0; r < 8; r++) begin
         int nb;
         nb = int'($urandom_range(4, 1));
         q = {};
         for (int k = 0; k < nb; k++) q.push_back(8'($urandom));
         run_frame($sformatf("rand%0d", r), q, none, int'($urandom_range(60, 0)), 0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
